// File: rtl/prim_chk_pkg.sv
// Shared types and constants for the logic-primitive checker.
package prim_chk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      SAMPLE,
      DONE
   } chkStateT;

   localparam int NumVectors = 4;
   localparam int NumGates   = 5;

   localparam int GateNot  = 0;
   localparam int GateOr   = 1;
   localparam int GateAnd  = 2;
   localparam int GateNand = 3;
   localparam int GateXor  = 4;

   localparam int SettleMin = 1;
   localparam int SettleMax = 15;

   function automatic logic [2:0] countOnes(input logic [NumGates-1:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < NumGates; i++) begin
         n = n + 3'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/prim_expect.sv
// Golden model: expected response of each gate under test for stimulus a, b.
module prim_expect
   import prim_chk_pkg::*;
(
   input  logic                a,
   input  logic                b,
   output logic [NumGates-1:0] expected
);

   always_comb begin
      expected           = '0;
      expected[GateNot]  = ~a;
      expected[GateOr]   = a | b;
      expected[GateAnd]  = a & b;
      expected[GateNand] = ~(a & b);
      expected[GateXor]  = a ^ b;
   end

endmodule

// File: rtl/prim_checker.sv
// Built-in self check sweeping four a/b vectors through five gates and tallying mismatches.
// Optional early abort on first failing vector: define PRIM_CHECKER_STOP_ON_FAIL_EN.
//
// state  | meaning
// IDLE   | waiting for start after reset
// DRIVE  | register a/b from the current vector index
// SETTLE | wait SETTLE_CYCLES for the gates to respond
// SAMPLE | compare responses, accumulate errors, pick next vector or finish
// DONE   | results held, a/b held, waiting for a new start
module prim_checker
   import prim_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       not_out,
   input  logic       or_out,
   input  logic       and_out,
   input  logic       nand_out,
   input  logic       xor_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic [4:0] fail_vec
);

   localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);
   localparam logic [1:0] LastIdx    = 2'(NumVectors - 1);

   chkStateT            state;
   logic [1:0]          idx;
   logic [3:0]          settleCnt;
   logic [NumGates-1:0] expected;
   logic [NumGates-1:0] observed;
   logic [NumGates-1:0] mismatch;
   logic [4:0]          errNext;
   logic                finishSweep;

   prim_expect uExpect (
      .a        (a),
      .b        (b),
      .expected (expected)
   );

   always_comb begin
      observed           = '0;
      observed[GateNot]  = not_out;
      observed[GateOr]   = or_out;
      observed[GateAnd]  = and_out;
      observed[GateNand] = nand_out;
      observed[GateXor]  = xor_out;
   end

   // At most 5 mismatches per vector over 4 vectors, so the 5-bit sum cannot wrap.
   assign mismatch = observed ^ expected;
   assign errNext  = err_count + 5'(countOnes(mismatch));

`ifdef PRIM_CHECKER_STOP_ON_FAIL_EN
   assign finishSweep = (idx == LastIdx) || (|mismatch);
`else
   assign finishSweep = (idx == LastIdx);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         settleCnt <= '0;
         a         <= 1'b0;
         b         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_vec  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= DRIVE;
                  idx       <= '0;
                  err_count <= '0;
                  fail_vec  <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
               end
            end
            DRIVE: begin
               a         <= idx[0];
               b         <= idx[1];
               settleCnt <= SettleLoad;
               state     <= SETTLE;
            end
            SETTLE: begin
               if (settleCnt == '0) begin
                  state <= SAMPLE;
               end else begin
                  settleCnt <= settleCnt - 4'd1;
               end
            end
            SAMPLE: begin
               err_count <= errNext;
               fail_vec  <= fail_vec | mismatch;
               if (finishSweep) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (errNext == '0);
               end else begin
                  idx   <= idx + 2'd1;
                  state <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
